sine_wg_seq: RTL

- Multichannel phase-step sequencer directly upstream of the CORDIC sine wave generator (sine_wg_cor).
- Holds one phase increment per channel, plus a pending phase-zero request per channel.
- On each sample tick, snapshots the configuration and issues one phase word per channel, channel 0 first, over a valid/ready stream matching the generator's s_sine_* slave port.
- Gives the generator a consistent per-sample channel sweep and absorbs downstream backpressure.

---
 rtl/sine_wg_seq_if.sv | 40 ++++
 rtl/sine_wg_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sine_wg_seq_if.sv
// sine_wg_seq_if
//   Bundles the two streams of the phase-step sequencer:
//   - configuration write port (s_step_*): step value, zero request and
//     target channel, with valid/ready handshake.
//   - phase word stream towards the CORDIC generator (m_sine_*), shaped
//     like the generator's s_sine_* slave port.
//   Modports:
//   - slave  : sequencer side (accepts config, drives the phase stream).
//   - master : environment side (drives config, consumes the phase stream).
interface sine_wg_seq_if #(
   parameter int NR_CHANNELS   = 3,
   parameter int CHANNEL_WIDTH = $clog2(NR_CHANNELS),
   parameter int RADIAN_WIDTH  = 28
);
   logic [RADIAN_WIDTH-1:0]  s_step_d;
   logic                     s_step_zero;
   logic [CHANNEL_WIDTH-1:0] s_step_ch;
   logic                     s_step_dv;
   logic                     s_step_dr;

   logic [RADIAN_WIDTH-1:0]  m_sine_d;
   logic                     m_sine_zero;
   logic [CHANNEL_WIDTH-1:0] m_sine_ch;
   logic                     m_sine_dv;
   logic                     m_sine_dr;

   modport slave (
      input  s_step_d, s_step_zero, s_step_ch, s_step_dv,
      output s_step_dr,
      output m_sine_d, m_sine_zero, m_sine_ch, m_sine_dv,
      input  m_sine_dr
   );

   modport master (
      output s_step_d, s_step_zero, s_step_ch, s_step_dv,
      input  s_step_dr,
      input  m_sine_d, m_sine_zero, m_sine_ch, m_sine_dv,
      output m_sine_dr
   );
endinterface

// File: rtl/sine_wg_seq.sv
// sine_wg_seq
//   Multichannel phase-step sequencer feeding the CORDIC sine generator.
//   Keeps a shadow table of per-channel phase increments and phase-zero
//   requests written through the config port. A sample tick snapshots the
//   shadow table into the active table and then issues one phase word per
//   channel (channel 0 first) on the m_sine_* stream, holding each beat
//   stable under backpressure.
//   Ports:
//   - clk, rst     : system clock, asynchronous active-high reset.
//   - s_if         : config write stream + phase word stream (slave modport).
//   - sample_tick  : one-cycle pulse that starts a sweep.
//   - busy         : high while a sweep is being issued.
//   - overrun      : one-cycle pulse when a tick arrives during a sweep.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for sample_tick; no beat offered
//   ST_ISSUE | offering the beat for channel r_ch; advance on handshake
module sine_wg_seq #(
   parameter int NR_CHANNELS   = 3,
   parameter int CHANNEL_WIDTH = $clog2(NR_CHANNELS),
   parameter int RADIAN_WIDTH  = 28
) (
   input  logic             clk,
   input  logic             rst,
   sine_wg_seq_if.slave     s_if,
   input  logic             sample_tick,
   output logic             busy,
   output logic             overrun
);

   localparam logic [CHANNEL_WIDTH-1:0] LP_LAST_CH = CHANNEL_WIDTH'(NR_CHANNELS - 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

   state_t                                    r_state;
   state_t                                    w_state_nxt;
   logic [CHANNEL_WIDTH-1:0]                  r_ch;
   logic [CHANNEL_WIDTH-1:0]                  w_ch_nxt;

   logic [NR_CHANNELS-1:0][RADIAN_WIDTH-1:0]  r_shadow_step;
   logic [NR_CHANNELS-1:0][RADIAN_WIDTH-1:0]  r_active_step;
   logic [NR_CHANNELS-1:0][RADIAN_WIDTH-1:0]  w_shadow_step_upd;
   logic [NR_CHANNELS-1:0]                    r_shadow_zero;
   logic [NR_CHANNELS-1:0]                    r_active_zero;
   logic [NR_CHANNELS-1:0]                    w_zero_req;

   logic                                      r_step_dr;
   logic                                      r_overrun;
   logic                                      w_wr_take;
   logic                                      w_tick_take;
   logic                                      w_xfer;
   logic [RADIAN_WIDTH-1:0]                   w_cur_step;
   logic                                      w_cur_zero;

   // ------------------------------------------------------------------
   // Config write decode
   // ------------------------------------------------------------------
   assign w_wr_take = s_if.s_step_dv & r_step_dr;

   // Shadow table as it will look after this edge's write. Channel
   // indices beyond NR_CHANNELS-1 match no entry, so such writes vanish.
   always_comb begin
      w_shadow_step_upd = r_shadow_step;
      w_zero_req        = '0;
      for (int i = 0; i < NR_CHANNELS; i++) begin
         if (w_wr_take && (s_if.s_step_ch == CHANNEL_WIDTH'(i))) begin
            w_shadow_step_upd[i] = s_if.s_step_d;
            w_zero_req[i]        = s_if.s_step_zero;
         end
      end
   end

   assign w_tick_take = (r_state == ST_IDLE) & sample_tick;
   assign w_xfer      = (r_state == ST_ISSUE) & s_if.m_sine_dr;

   // ------------------------------------------------------------------
   // Shadow / active tables
   // ------------------------------------------------------------------
   // On an accepted tick the snapshot includes a same-edge write. Zero
   // requests are consumed by the snapshot, so the shadow flags clear
   // (a same-edge zero request goes straight into the active flags).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow_step <= '0;
         r_shadow_zero <= '0;
         r_active_step <= '0;
         r_active_zero <= '0;
      end else begin
         r_shadow_step <= w_shadow_step_upd;
         if (w_tick_take) begin
            r_active_step <= w_shadow_step_upd;
            r_active_zero <= r_shadow_zero | w_zero_req;
            r_shadow_zero <= '0;
         end else begin
            r_shadow_zero <= r_shadow_zero | w_zero_req;
         end
      end
   end

   // Ready comes up on the first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_step_dr <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_step_dr <= 1'b1;
         r_overrun <= sample_tick & (r_state != ST_IDLE);
      end
   end

   assign s_if.s_step_dr = r_step_dr;
   assign overrun        = r_overrun;

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_ch    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      case (r_state)
         ST_IDLE: begin
            if (w_tick_take) begin
               w_state_nxt = ST_ISSUE;
               w_ch_nxt    = '0;
            end
         end
         ST_ISSUE: begin
            if (w_xfer) begin
               if (r_ch == LP_LAST_CH) begin
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_ch_nxt = r_ch + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------
   // Active-table read for the current channel; a compare chain keeps the
   // select inside the table for any index width.
   always_comb begin
      w_cur_step = '0;
      w_cur_zero = 1'b0;
      for (int i = 0; i < NR_CHANNELS; i++) begin
         if (r_ch == CHANNEL_WIDTH'(i)) begin
            w_cur_step = r_active_step[i];
            w_cur_zero = r_active_zero[i];
         end
      end
   end

   // A zero request means absolute restart at phase 0, so the word is
   // forced to 0 rather than carrying the increment.
   always_comb begin
      s_if.m_sine_dv   = 1'b0;
      s_if.m_sine_ch   = '0;
      s_if.m_sine_d    = '0;
      s_if.m_sine_zero = 1'b0;
      busy             = 1'b0;
      if (r_state == ST_ISSUE) begin
         s_if.m_sine_dv   = 1'b1;
         s_if.m_sine_ch   = r_ch;
         busy             = 1'b1;
         s_if.m_sine_zero = w_cur_zero;
         s_if.m_sine_d    = w_cur_zero ? '0 : w_cur_step;
      end
   end

endmodule
